bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end that turns a WIDTH-bit word into a one-bit-per-cycle stream, LSB first.
- Drives the `inp` of the downstream two-consecutive-equal-bits Mealy detector, with a qualifier strobe and a frame marker.
- Upstream side uses a valid/ready load handshake; a pause input stalls the stream without losing bits.

Parameters:
- WIDTH, 16, data bits per frame (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream has a word on load_data.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- pause  input  1  hold the current bit; no advance this cycle.
- ser_bit  output  1  current serial bit; feeds detector inp.
- ser_valid  output  1  ser_bit is a live data bit this cycle.
- frame_done  output  1  high during the final bit cycle of a frame.
- busy  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is synchronous, active-high, and takes priority over everything, including a load in the same cycle.
  - After the reset edge: state=IDLE, shift reg=0, cnt=0.
  - Resulting output values: ser_bit=0, ser_valid=0, frame_done=0, busy=0, load_ready=1.
- States: IDLE, SHIFT.
- Output decode (all combinational from registered state; no combinational path from load_valid to any output):
  - ser_bit = shreg[0].
  - ser_valid = SHIFT && !pause.
  - busy = SHIFT.
  - frame_done = SHIFT && !pause && cnt==LAST, where LAST = WIDTH-1.
  - load_ready = IDLE || frame_done.
- Load:
  - Accept on a clock edge where load_valid && load_ready.
  - At that edge: shreg<=load_data, cnt<=0, state<=SHIFT.
  - Bit 0 is presented in the next cycle.
- SHIFT with pause=1: shreg, cnt and state hold; ser_valid=0; ser_bit stays stable.
- SHIFT with pause=0, cnt<LAST: shreg shifts right by 1 (0 into MSB); cnt<=cnt+1.
- SHIFT with pause=0, cnt==LAST:
  - With load accepted at this edge: reload, back-to-back with zero gap.
  - Otherwise: state<=IDLE, shreg<=0, cnt<=0.
- Latency: load edge → first bit = 1 cycle; frame = WIDTH unpaused cycles.
- load_valid while busy and not in the final bit cycle: ignored, load_ready=0; upstream must hold its word.
- Reset mid-frame: the frame is dropped with no frame_done; IDLE from the next cycle.
- pause in IDLE: no effect.
- pause in the final bit cycle: frame_done and load_ready both stay low until pause drops.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Each frame appends one even-parity bit, ^load_data captured at load, after data bit WIDTH-1.
  - LAST = WIDTH, so the frame is WIDTH+1 cycles.
  - frame_done asserts on the parity-bit cycle.
  - The parity bit is held in a dedicated register and shifted in at MSB on load.
- Undefined: WIDTH-bit frames, no parity register.

Decomposition:
- Package ser_pkg holds:
  - state encoding: IDLE=1'b0, SHIFT=1'b1;
  - SER_WIDTH default = 16;
  - even_parity function used under SER_PARITY_EN.
- No sub-module; a single flat module suffices.
- The bench instantiates bit_serializer → mealy with ser_bit→inp, gating the detector clock enable on ser_valid.

Test Plan:
- Basic frame: reset, then load 16'h5772 with pause=0 → ser_bit over 16 cycles = 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0.
  - ser_valid high for all 16 cycles.
  - frame_done only on cycle 16, then IDLE with load_ready=1.
- Back-to-back: hold load_valid=1 with 16'h5772 then 16'hFFFF.
  - The second word is accepted on frame_done of the first.
  - ser_valid stays high 32 consecutive cycles; bits 17-32 all 1.
- Pause: assert pause for 3 cycles starting at bit 5 of 16'h5772.
  - ser_bit holds 1, ser_valid=0 for 3 cycles.
  - The stream resumes with bit 5=1; frame takes 19 cycles.
- Busy reject: load 16'h00FF, then pulse load_valid with 16'h1234 at bit 3.
  - load_ready=0 at bit 3 and the second word is not accepted.
  - The stream is unchanged: 8×1 then 8×0.
- Reset mid-frame: rst=1 at bit 7 of 16'h5772.
  - Next cycle: ser_valid=0, busy=0, load_ready=1, no frame_done.
  - A subsequent load of 16'hAAAA streams 0,1,0,1,…
- SER_PARITY_EN: load 16'h5772 (popcount 9).
  - 17 bits out; bit 17 = 1.
  - frame_done on cycle 17.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared constants for the bit serializer: state encoding, default width, parity helper.
// The parity helper is used when the SER_PARITY_EN build option is enabled.
package ser_pkg;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  localparam int SER_WIDTH = 16;

  // Zero-extension leaves parity unchanged, so one 64-bit helper serves any width up to 64.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit word out LSB first, valid/ready load, pause stall.
// Build option SER_PARITY_EN appends an even-parity bit, making each frame WIDTH+1 cycles.
module bit_serializer
  import ser_pkg::*;
#(
  parameter  int WIDTH = SER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             pause,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

  logic             state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             msb_in;
  logic             load_fire;

`ifdef SER_PARITY_EN
  logic par_q;

  // Parity waits here and enters the MSB on the first shift, reaching bit 0 after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load_fire) begin
      par_q <= even_parity(64'(load_data));
    end else if (state_q == SHIFT && !pause) begin
      par_q <= 1'b0;
    end
  end

  assign msb_in = par_q;
`else
  assign msb_in = 1'b0;
`endif

  always_comb begin
    ser_bit    = shreg_q[0];
    busy       = (state_q == SHIFT);
    ser_valid  = busy && !pause;
    frame_done = ser_valid && (cnt_q == LAST);
    load_ready = (state_q == IDLE) || frame_done;
    load_fire  = load_valid && load_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load_fire) begin
      state_q <= SHIFT;
      shreg_q <= load_data;
      cnt_q   <= '0;
    end else if (state_q == SHIFT && !pause) begin
      if (cnt_q == LAST) begin
        state_q <= IDLE;
        shreg_q <= '0;
        cnt_q   <= '0;
      end else begin
        shreg_q <= {msb_in, shreg_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer with a behavioural two-equal-bits detector on ser_bit.
// Frame length follows SER_PARITY_EN (16 or 17 bits).
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int unsigned FL = 17;
`else
  localparam int unsigned FL = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic        pause = 1'b0;
  logic        ser_bit;
  logic        ser_valid;
  logic        frame_done;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit_serializer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .pause      (pause),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream Mealy detector, clock-enabled by ser_valid.
  logic        det_prev = 1'b0;
  logic        det_have = 1'b0;
  int unsigned det_cnt = 0;
  int unsigned busy_cycles = 0;

  always @(posedge clk) begin
    if (rst) begin
      det_have <= 1'b0;
      det_prev <= 1'b0;
    end else if (ser_valid) begin
      if (det_have && ser_bit == det_prev) det_cnt <= det_cnt + 1;
      det_prev <= ser_bit;
      det_have <= 1'b1;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ebit(input logic [15:0] w, input int unsigned i);
    return (i < 16) ? w[i] : ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Checks bits first..first+n-1 of a frame, one unpaused cycle each.
  task automatic stream(input string tag, input logic [15:0] w,
                        input int unsigned first, input int unsigned n);
    for (int unsigned i = first; i < first + n; i++) begin
      #1;
      chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
      chk({tag, "_bit"}, 32'(ser_bit), 32'(ebit(w, i)));
      chk({tag, "_done"}, 32'(frame_done), 32'(i == FL - 1));
      chk({tag, "_ready"}, 32'(load_ready), 32'(i == FL - 1));
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_idle_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
  endtask

  int unsigned d0;
  int unsigned b0;

  initial begin
    // Reset, with a competing load that must lose
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 16'h5772;
    tick();
    rst = 1'b0;
    load_valid = 1'b0;
    chk_idle("reset");
    chk("reset_bit", 32'(ser_bit), 32'd0);

    // Basic frame; 5772 LSB-first has five equal adjacent pairs
    d0 = det_cnt;
    load(16'h5772);
    stream("basic", 16'h5772, 0, FL);
    chk_idle("basic");
    chk("basic_det", det_cnt - d0, 32'd5);

    // Back-to-back: second word taken on frame_done of the first
    load_valid = 1'b1;
    load_data  = 16'h5772;
    tick();
    load_data  = 16'hFFFF;
    stream("b2b_a", 16'h5772, 0, FL);
    load_valid = 1'b0;
    stream("b2b_b", 16'hFFFF, 0, FL);
    chk_idle("b2b");

    // Pause for 3 cycles while bit 5 (=1) is presented
    b0 = busy_cycles;
    load(16'h5772);
    stream("pause_pre", 16'h5772, 0, 5);
    pause = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk("pause_valid", 32'(ser_valid), 32'd0);
      chk("pause_bit", 32'(ser_bit), 32'd1);
      chk("pause_busy", 32'(busy), 32'd1);
      chk("pause_done", 32'(frame_done), 32'd0);
      tick();
    end
    pause = 1'b0;
    stream("pause_post", 16'h5772, 5, FL - 5);
    chk_idle("pause");
    chk("pause_len", busy_cycles - b0, 32'(FL + 3));

    // Pause on the final bit holds frame_done and load_ready low
    load(16'h00FF);
    stream("lastp_pre", 16'h00FF, 0, FL - 1);
    pause = 1'b1;
    #1;
    chk("lastp_done", 32'(frame_done), 32'd0);
    chk("lastp_ready", 32'(load_ready), 32'd0);
    tick();
    pause = 1'b0;
    stream("lastp_post", 16'h00FF, FL - 1, 1);
    chk_idle("lastp");

    // Busy reject: a load at bit 3 is ignored
    load(16'h00FF);
    stream("rej_pre", 16'h00FF, 0, 3);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    #1;
    chk("rej_ready", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    stream("rej_post", 16'h00FF, 4, FL - 4);
    chk_idle("rej");

    // Reset mid-frame at bit 7, then a fresh frame
    load(16'h5772);
    stream("rmid_pre", 16'h5772, 0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rmid");
    load(16'hAAAA);
    stream("rmid_aaaa", 16'hAAAA, 0, FL);
    chk_idle("rmid_aaaa");

    // Pause in IDLE has no effect
    pause = 1'b1;
    tick();
    chk_idle("idle_pause");
    pause = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
